keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/keypad_scanner_debouncer.sv | 30 +++
 rtl/keypad_scanner.sv | 112 +++++++++++
 tb/tb_keypad_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_W  = 4;
  localparam int CNT_W = 22;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Legend printed on the pad, indexed by driven row and sensed column.
  function automatic logic [3:0] keymap(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] low_col(
    input logic [KP_W-1:0] c
  );
    logic [1:0] i;
    i = 2'd0;
    for (int k = KP_W - 1; k >= 0; k--) begin
      if (!c[k]) i = 2'(k);
    end
    return i;
  endfunction

  function automatic logic [KP_W-1:0] row_of(
    input logic [1:0] r
  );
    return ~(KP_W'(1) << r);
  endfunction

endpackage

// File: rtl/keypad_scanner_debouncer.sv
// Saturating stability counter; done flags DEBOUNCE_CYCLES-1 matches.
module debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2400000
) (
  input  logic clk,
  input  logic reset,
  input  logic match,
  input  logic clear,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (match && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller with press and release debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 48000,
  parameter int DEBOUNCE_CYCLES = 2400000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [KP_W-1:0] col,
  output logic [KP_W-1:0] row,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);

  state_t          state;
  logic [1:0]      ridx;
  logic [1:0]      cidx;
  logic [DW-1:0]   dwell;
  logic [KP_W-1:0] sync1;
  logic [KP_W-1:0] cols;
  logic [KP_W-1:0] col_l;
  logic            match;
  logic            clear;
  logic            done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      cols  <= '1;
    end else begin
      sync1 <= col;
      cols  <= sync1;
    end
  end

  // Release debounce waits for all-high; press debounce for the latched pattern.
  assign match = (state == RELEASE) ? (cols == '1) : (cols == col_l);
  assign clear = !((state == DEBOUNCE) || (state == RELEASE)) || !match || done;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .match(match),
    .clear(clear),
    .done (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      ridx      <= 2'd0;
      row       <= row_of(2'd0);
      cidx      <= 2'd0;
      dwell     <= '0;
      col_l     <= '1;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell == DWELL_END) begin
            dwell <= '0;
            if (cols == '1) begin
              ridx <= ridx + 2'd1;
              row  <= row_of(ridx + 2'd1);
            end else begin
              col_l <= cols;
              cidx  <= low_col(cols);
              state <= DEBOUNCE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= SCAN;
          end else if (done) begin
            key_valid <= 1'b1;
            key_code  <= keymap(ridx, cidx);
            key_held  <= 1'b1;
            state     <= HELD;
          end
        end
        HELD: begin
          if (cols == '1) state <= RELEASE;
        end
        RELEASE: begin
          if (!match) begin
            state <= HELD;
          end else if (done) begin
            key_held <= 1'b0;
            ridx     <= ridx + 2'd1;
            row      <= row_of(ridx + 2'd1);
            state    <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: pad model drives columns, spec-level model checks outputs.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;

  logic       use_keys = 1'b1;
  logic [3:0] direct = 4'hF;
  logic [3:0] pat [4];

  function automatic logic [3:0] pad(input logic [3:0] rw);
    logic [3:0] v = 4'hF;
    for (int i = 0; i < 4; i++)
      if (rw == (4'hF ^ (4'd1 << i))) v = pat[i];
    return v;
  endfunction

  initial forever begin
    @(negedge clk);
    col = use_keys ? pad(row) : direct;
  end

  // Behavioural model: phase 0 scan, 1 press debounce, 2 held, 3 release.
  string      KEYS = "123A456B789CE0FD";
  int         ph, r, t, lc;
  logic [3:0] c1, c2, cs, latched, m_code;
  logic       m_valid, m_held;

  function automatic logic [3:0] hexv(input int ch);
    return 4'((ch >= 65) ? ch - 55 : ch - 48);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; r = 0; t = 0; lc = 0;
      c1 = 4'hF; c2 = 4'hF; latched = 4'hF;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    end else begin
      cs = c2; c2 = c1; c1 = col;
      m_valid = 1'b0;
      case (ph)
        0: if (t == SD - 1) begin
             t = 0;
             if (cs == 4'hF) r = (r + 1) % 4;
             else begin
               latched = cs; lc = 0;
               while (cs[lc]) lc++;
               ph = 1;
             end
           end else t++;
        1: if (cs != latched) begin ph = 0; t = 0; end
           else if (t == DB - 1) begin
             m_valid = 1'b1;
             m_code = hexv(int'(KEYS.getc(r * 4 + lc)));
             m_held = 1'b1; ph = 2; t = 0;
           end else t++;
        2: if (cs == 4'hF) begin ph = 3; t = 0; end
        default:
           if (cs != 4'hF) begin ph = 2; t = 0; end
           else if (t == DB - 1) begin
             ph = 0; t = 0; r = (r + 1) % 4; m_held = 1'b0;
           end else t++;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (key_valid) pulses++;
    compared++;
    if (row !== (4'hF ^ (4'd1 << r)) || key_code !== m_code ||
        key_valid !== m_valid || key_held !== m_held) begin
      mismatched++;
      $display("FAIL cycle t=%0t row=%h/%h code=%h/%h valid=%b/%b held=%b/%b",
               $time, row, 4'hF ^ (4'd1 << r), key_code, m_code,
               key_valid, m_valid, key_held, m_held);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int n = 0;
    while (!key_valid && n < budget) begin cyc(1); n++; end
    compared++;
    if (!key_valid) begin
      mismatched++;
      $display("FAIL %s no key_valid within %0d cycles", name, n);
    end
  endtask

  task automatic wait_free(input string name, input int budget);
    int n = 0;
    while (key_held && n < budget) begin cyc(1); n++; end
    compared++;
    if (key_held) begin
      mismatched++;
      $display("FAIL %s key_held still 1 after %0d cycles", name, n);
    end
  endtask

  task automatic wait_deb(input int budget);
    int n = 0;
    while (!(ph == 1 && t == 3) && n < budget) begin cyc(1); n++; end
    compared++;
    if (!(ph == 1 && t == 3)) begin
      mismatched++;
      $display("FAIL reach_debounce not reached in %0d cycles", n);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_row"}, row, 4'hE);
    chk({name, "_code"}, key_code, 0);
    chk({name, "_valid"}, key_valid, 0);
    chk({name, "_held"}, key_held, 0);
  endtask

  logic [3:0] rows [41];
  int p0;

  initial begin
    for (int i = 0; i < 4; i++) pat[i] = 4'hF;
    #1 reset = 1'b1;
    #1 chk_reset("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan
    p0 = pulses;
    for (int k = 1; k <= 40; k++) begin cyc(1); rows[k] = row; end
    chk("idle_row_e2", rows[2], 4'hE);
    chk("idle_row_e5", rows[5], 4'hD);
    chk("idle_row_e9", rows[9], 4'hB);
    chk("idle_row_e13", rows[13], 4'h7);
    chk("idle_row_e17", rows[17], 4'hE);
    chk("idle_pulses", pulses - p0, 0);

    // Press key 8 (row2, col1)
    p0 = pulses;
    pat[2] = 4'b1101;
    wait_pulse("press8", 200);
    chk("press8_code", key_code, 4'h8);
    chk("press8_held", key_held, 1);
    chk("press8_row", row, 4'hB);
    cyc(30);
    chk("press8_pulses", pulses - p0, 1);

    // Release with a glitch back to pressed
    p0 = pulses;
    use_keys = 1'b0;
    direct = 4'hF; cyc(5);
    direct = 4'b1101; cyc(2);
    direct = 4'hF;
    cyc(6);
    chk("release_still_held", key_held, 1);
    wait_free("release", 40);
    chk("release_row", row, 4'h7);
    chk("release_pulses", pulses - p0, 0);
    use_keys = 1'b1;

    // Bounce on row2
    p0 = pulses;
    for (int k = 0; k < 40; k++) begin
      pat[2] = (k % 2 == 0) ? 4'b1101 : 4'hF;
      cyc(3);
    end
    pat[2] = 4'hF;
    cyc(10);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_held", key_held, 0);

    // Two keys on row0, then extra keys while held
    p0 = pulses;
    pat[0] = 4'b1100;
    wait_pulse("multi", 200);
    chk("multi_code", key_code, 4'h1);
    chk("multi_row", row, 4'hE);
    pat[0] = 4'b0100;
    pat[1] = 4'b1110;
    cyc(30);
    chk("multi_pulses", pulses - p0, 1);
    chk("multi_code_kept", key_code, 4'h1);
    for (int i = 0; i < 4; i++) pat[i] = 4'hF;
    wait_free("multi_release", 40);
    chk("multi_release_row", row, 4'hD);

    // Reset mid-debounce
    p0 = pulses;
    pat[2] = 4'b1101;
    wait_deb(200);
    #2 reset = 1'b1;
    #1 chk_reset("rst_deb");
    pat[2] = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    chk("rst_deb_row_after", row, 4'hE);
    chk("rst_deb_pulses", pulses - p0, 0);

    // Reset mid-held
    pat[2] = 4'b1101;
    wait_pulse("press_again", 200);
    chk("press_again_code", key_code, 4'h8);
    cyc(3);
    #2 reset = 1'b1;
    #1 chk_reset("rst_held");
    pat[2] = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
